conv_result_writer: RTL and testbench

//  Consumer end of the convolve pixel stream: accepts 19-bit signed convolution results,

---
 rtl/conv_pkg.sv | 23 ++
 rtl/conv_requant.sv | 48 ++++
 rtl/conv_result_writer.sv | 176 +++++++++++++++++
 tb/tb_conv_result_writer.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared constants and writer state encoding for the convolution pipeline.
// Contents:
//   IMG_NB, KERNEL_NB, ACC_NB, KERNEL_SIZE   default datapath widths / kernel side
//   WR_IDLE, WR_RUN, WR_DONE                  result-writer state codes
//   wr_state_t                                enum built on those codes
package conv_pkg;

    localparam int unsigned IMG_NB      = 7;
    localparam int unsigned KERNEL_NB   = 8;
    localparam int unsigned ACC_NB      = 19;
    localparam int unsigned KERNEL_SIZE = 3;

    localparam logic [1:0] WR_IDLE = 2'd0;
    localparam logic [1:0] WR_RUN  = 2'd1;
    localparam logic [1:0] WR_DONE = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = WR_IDLE,
        ST_RUN  = WR_RUN,
        ST_DONE = WR_DONE
    } wr_state_t;

endpackage

// File: rtl/conv_requant.sv
// Combinational requantizer: signed accumulator -> unsigned pixel.
// The accumulator is arithmetically shifted right by SHIFT, then clamped to
// the range [0, 2^IMG_NB-1].
// Configuration macro: CONV_WR_ROUND_EN adds 2^(SHIFT-1) before the shift
// (round half-up, sum kept one bit wider); otherwise plain floor truncation.
// Ports:
//   acc    in   ACC_NB   signed accumulator
//   pix_c  out  IMG_NB   requantized pixel (combinational)
module conv_requant #(
    parameter int unsigned ACC_NB = conv_pkg::ACC_NB,
    parameter int unsigned IMG_NB = conv_pkg::IMG_NB,
    parameter int unsigned SHIFT  = 8
) (
    input  logic signed [ACC_NB-1:0] acc,
    output logic        [IMG_NB-1:0] pix_c
);

`ifdef CONV_WR_ROUND_EN
    localparam int unsigned T_NB = ACC_NB + 1;
    localparam logic [T_NB-1:0] HALF = T_NB'(1) << (SHIFT - 1);

    logic signed [T_NB-1:0] sum_c;
    logic signed [T_NB-1:0] t_c;

    // Widen by one bit so the rounding offset cannot overflow.
    assign sum_c = $signed({acc[ACC_NB-1], acc}) + $signed(HALF);
    assign t_c   = sum_c >>> SHIFT;
`else
    localparam int unsigned T_NB = ACC_NB;

    logic signed [T_NB-1:0] t_c;

    assign t_c = acc >>> SHIFT;
`endif

    localparam logic [T_NB-1:0] PIX_MAX = T_NB'((1 << IMG_NB) - 1);

    // Clamp negatives to zero and large positives to full scale.
    always_comb begin
        pix_c = t_c[IMG_NB-1:0];
        if (t_c[T_NB-1]) begin
            pix_c = '0;
        end else if ($unsigned(t_c) > PIX_MAX) begin
            pix_c = '1;
        end
    end

endmodule

// File: rtl/conv_result_writer.sv
// Result writer: consumer end of the convolve pixel stream.
// Accepts signed convolution results, requantizes them and writes them to the
// output frame RAM at linear raster addresses of the valid-convolution frame
// (OUT_H x OUT_W). One output register gives full throughput with backpressure.
// Configuration macro: CONV_WR_ROUND_EN (forwarded to conv_requant) selects
// round half-up instead of truncation.
// Ports:
//   clk100        in   1        clock, rising edge
//   in_reset      in   1        synchronous reset, active-high
//   i_start       in   1        arm for a new frame (honoured in IDLE only)
//   i_valid       in   1        i_pixel carries a result
//   i_pixel       in   ACC_NB   signed convolution result
//   o_ready       out  1        beat = i_valid & o_ready (combinational on i_wr_ready)
//   o_wr_en       out  1        RAM write request, held until i_wr_ready
//   o_wr_addr     out  ADDR_NB  row*OUT_W+col
//   o_wr_data     out  IMG_NB   requantized pixel
//   i_wr_ready    in   1        RAM accepts the write
//   o_busy        out  1        high while running a frame
//   o_frame_done  out  1        one-cycle pulse after the final write
module conv_result_writer #(
    parameter int unsigned IMG_HEIGHT  = 480,
    parameter int unsigned IMG_WIDTH   = 640,
    parameter int unsigned KERNEL_SIZE = conv_pkg::KERNEL_SIZE,
    parameter int unsigned IMG_NB      = conv_pkg::IMG_NB,
    parameter int unsigned ACC_NB      = conv_pkg::ACC_NB,
    parameter int unsigned SHIFT       = 8,
    parameter int unsigned ADDR_NB     = 19
) (
    input  logic                     clk100,
    input  logic                     in_reset,
    input  logic                     i_start,
    input  logic                     i_valid,
    input  logic signed [ACC_NB-1:0] i_pixel,
    output logic                     o_ready,
    output logic                     o_wr_en,
    output logic       [ADDR_NB-1:0] o_wr_addr,
    output logic        [IMG_NB-1:0] o_wr_data,
    input  logic                     i_wr_ready,
    output logic                     o_busy,
    output logic                     o_frame_done
);

    import conv_pkg::*;

    localparam int unsigned OUT_H  = IMG_HEIGHT - KERNEL_SIZE + 1;
    localparam int unsigned OUT_W  = IMG_WIDTH - KERNEL_SIZE + 1;
    localparam int unsigned ROW_NB = (OUT_H > 1) ? $clog2(OUT_H) : 1;
    localparam int unsigned COL_NB = (OUT_W > 1) ? $clog2(OUT_W) : 1;

    wr_state_t state_q;
    wr_state_t state_d;

    logic [ROW_NB-1:0]  row_q;
    logic [COL_NB-1:0]  col_q;
    logic [ADDR_NB-1:0] addr_q;
    logic               beats_done_q;   // every beat of the frame has been taken
    logic               wr_last_q;      // write register holds the frame's final pixel

    logic [IMG_NB-1:0]  pix_c;
    logic               ready_c;
    logic               beat_c;
    logic               wr_fire_c;
    logic               last_beat_c;
    logic               frame_end_c;
    logic               busy_d;
    logic               done_d;

    // Requantize the incoming accumulator.
    conv_requant #(
        .ACC_NB (ACC_NB),
        .IMG_NB (IMG_NB),
        .SHIFT  (SHIFT)
    ) u_requant (
        .acc   (i_pixel),
        .pix_c (pix_c)
    );

    // Handshake terms; ready looks through the RAM's ready to avoid a bubble.
    assign ready_c     = (state_q == ST_RUN) && !beats_done_q && (!o_wr_en || i_wr_ready);
    assign beat_c      = i_valid && ready_c;
    assign wr_fire_c   = o_wr_en && i_wr_ready;
    assign last_beat_c = (row_q == ROW_NB'(OUT_H - 1)) && (col_q == COL_NB'(OUT_W - 1));
    assign frame_end_c = wr_fire_c && wr_last_q;
    assign o_ready     = ready_c;

    // State register.
    always_ff @(posedge clk100) begin
        if (in_reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and next values of the registered status outputs.
    always_comb begin
        state_d = state_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (frame_end_c) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    // Status outputs.
    always_ff @(posedge clk100) begin
        if (in_reset) begin
            o_busy       <= 1'b0;
            o_frame_done <= 1'b0;
        end else begin
            o_busy       <= busy_d;
            o_frame_done <= done_d;
        end
    end

    // Raster counters: cleared on a new frame, advanced once per accepted beat.
    always_ff @(posedge clk100) begin
        if (in_reset) begin
            row_q        <= '0;
            col_q        <= '0;
            addr_q       <= '0;
            beats_done_q <= 1'b0;
        end else if ((state_q == ST_IDLE) && i_start) begin
            row_q        <= '0;
            col_q        <= '0;
            addr_q       <= '0;
            beats_done_q <= 1'b0;
        end else if (beat_c) begin
            addr_q <= addr_q + ADDR_NB'(1);
            if (last_beat_c) begin
                beats_done_q <= 1'b1;
            end else if (col_q == COL_NB'(OUT_W - 1)) begin
                col_q <= '0;
                row_q <= row_q + ROW_NB'(1);
            end else begin
                col_q <= col_q + COL_NB'(1);
            end
        end
    end

    // Output write register: load on a beat, hold under backpressure, drop on handover.
    always_ff @(posedge clk100) begin
        if (in_reset) begin
            o_wr_en   <= 1'b0;
            o_wr_addr <= '0;
            o_wr_data <= '0;
            wr_last_q <= 1'b0;
        end else if (beat_c) begin
            o_wr_en   <= 1'b1;
            o_wr_addr <= addr_q;
            o_wr_data <= pix_c;
            wr_last_q <= last_beat_c;
        end else if (wr_fire_c) begin
            o_wr_en   <= 1'b0;
            wr_last_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_conv_result_writer.sv
// Directed bench for conv_result_writer on a 4x4 image (2x2 output frame).
module tb_conv_result_writer;

`ifdef CONV_WR_ROUND_EN
    localparam int ROUND = 1;
`else
    localparam int ROUND = 0;
`endif

    logic        clk100 = 1'b0;
    logic        in_reset;
    logic        i_start;
    logic        i_valid;
    logic [18:0] i_pixel;
    logic        o_ready;
    logic        o_wr_en;
    logic [18:0] o_wr_addr;
    logic [6:0]  o_wr_data;
    logic        i_wr_ready;
    logic        o_busy;
    logic        o_frame_done;

    int errors = 0;
    int checks = 0;
    int hs_count = 0;
    int hs_addr_sum = 0;

    int px_b2b [4] = '{1280, 1280, 1280, 1280};
    int ex_b2b [4] = '{5, 5, 5, 5};
    int px_clp [4] = '{-300, 40000, 32767, 255};
    int ex_clp [4] = '{0, 127, 127, ROUND};
    int px_rnd [4] = '{384, 383, 0, 0};
    int ex_rnd [4] = '{1 + ROUND, 1, 0, 0};

    always #5 clk100 = ~clk100;

    conv_result_writer #(
        .IMG_HEIGHT (4),
        .IMG_WIDTH  (4),
        .SHIFT      (8)
    ) dut (
        .clk100       (clk100),
        .in_reset     (in_reset),
        .i_start      (i_start),
        .i_valid      (i_valid),
        .i_pixel      (i_pixel),
        .o_ready      (o_ready),
        .o_wr_en      (o_wr_en),
        .o_wr_addr    (o_wr_addr),
        .o_wr_data    (o_wr_data),
        .i_wr_ready   (i_wr_ready),
        .o_busy       (o_busy),
        .o_frame_done (o_frame_done)
    );

    // Count completed RAM writes to detect loss or duplication.
    always @(posedge clk100) begin
        if (o_wr_en === 1'b1 && i_wr_ready === 1'b1) begin
            hs_count    <= hs_count + 1;
            hs_addr_sum <= hs_addr_sum + int'(o_wr_addr);
        end
    end

    task automatic apply_reset();
        @(negedge clk100);
        in_reset = 1'b1; i_start = 1'b0; i_valid = 1'b0; i_pixel = '0; i_wr_ready = 1'b0;
        @(negedge clk100);
        @(negedge clk100);
        in_reset = 1'b0;
    endtask

    task automatic test_reset();
        in_reset = 1'b1; i_start = 1'b0; i_valid = 1'b0; i_pixel = '0; i_wr_ready = 1'b0;
        repeat (2) @(negedge clk100);
        checks++;
        if ({o_wr_en, o_busy, o_frame_done} !== 3'b000) begin
            errors++; $display("FAIL reset_flags got=%b exp=000", {o_wr_en, o_busy, o_frame_done});
        end
        checks++;
        if (o_wr_addr !== 19'd0 || o_wr_data !== 7'd0) begin
            errors++; $display("FAIL reset_bus got addr=%0d data=%0d exp 0/0", o_wr_addr, o_wr_data);
        end
        checks++;
        if (o_ready !== 1'b0) begin
            errors++; $display("FAIL reset_ready got=%b exp=0", o_ready);
        end
        in_reset = 1'b0;

        // Reset in the middle of a stalled write.
        @(negedge clk100);
        i_start = 1'b1;
        @(negedge clk100);
        i_start = 1'b0; i_valid = 1'b1; i_pixel = 19'(1280); i_wr_ready = 1'b0;
        @(negedge clk100);
        i_valid = 1'b0;
        checks++;
        if (o_wr_en !== 1'b1 || o_wr_addr !== 19'd0 || o_wr_data !== 7'd5) begin
            errors++; $display("FAIL midwrite_pre got en=%b addr=%0d data=%0d exp 1/0/5",
                               o_wr_en, o_wr_addr, o_wr_data);
        end
        in_reset = 1'b1; i_start = 1'b1; i_valid = 1'b1;
        @(negedge clk100);
        checks++;
        if ({o_wr_en, o_busy, o_frame_done} !== 3'b000 || o_wr_addr !== 19'd0 || o_wr_data !== 7'd0) begin
            errors++; $display("FAIL midwrite_reset got en=%b busy=%b done=%b addr=%0d data=%0d exp all 0",
                               o_wr_en, o_busy, o_frame_done, o_wr_addr, o_wr_data);
        end
        checks++;
        if (o_ready !== 1'b0) begin
            errors++; $display("FAIL midwrite_ready got=%b exp=0", o_ready);
        end
        in_reset = 1'b0; i_start = 1'b0; i_valid = 1'b0;
        @(negedge clk100);
        checks++;
        if (o_busy !== 1'b0 || o_wr_en !== 1'b0) begin
            errors++; $display("FAIL midwrite_idle got busy=%b en=%b exp 0/0", o_busy, o_wr_en);
        end
    endtask

    // One full frame of back-to-back beats with the RAM always ready.
    task automatic test_frame(input string name, input int px [4], input int ex [4]);
        apply_reset();
        @(negedge clk100);
        i_start = 1'b1; i_valid = 1'b0; i_wr_ready = 1'b1;
        @(negedge clk100);
        i_start = 1'b0;
        checks++;
        if (o_busy !== 1'b1) begin
            errors++; $display("FAIL %s_busy got=%b exp=1", name, o_busy);
        end
        for (int i = 0; i < 5; i++) begin
            if (i == 0) begin
                checks++;
                if (o_wr_en !== 1'b0) begin
                    errors++; $display("FAIL %s_early_wr got=%b exp=0", name, o_wr_en);
                end
            end else begin
                checks++;
                if (o_wr_en !== 1'b1 || o_wr_addr !== 19'(i - 1) || o_wr_data !== 7'(ex[i - 1])) begin
                    errors++; $display("FAIL %s_write[%0d] got en=%b addr=%0d data=%0d exp 1/%0d/%0d",
                                       name, i - 1, o_wr_en, o_wr_addr, o_wr_data, i - 1, ex[i - 1]);
                end
            end
            checks++;
            if (o_frame_done !== 1'b0) begin
                errors++; $display("FAIL %s_done_early[%0d] got=%b exp=0", name, i, o_frame_done);
            end
            i_valid = 1'b1;
            i_pixel = 19'(px[(i < 4) ? i : 0]);
            #1;
            checks++;
            if (o_ready !== ((i < 4) ? 1'b1 : 1'b0)) begin
                errors++; $display("FAIL %s_ready[%0d] got=%b exp=%0d", name, i, o_ready, (i < 4));
            end
            @(negedge clk100);
        end
        i_valid = 1'b0;
        checks++;
        if (o_frame_done !== 1'b1 || o_wr_en !== 1'b0 || o_busy !== 1'b0) begin
            errors++; $display("FAIL %s_done got done=%b en=%b busy=%b exp 1/0/0",
                               name, o_frame_done, o_wr_en, o_busy);
        end
        @(negedge clk100);
        checks++;
        if (o_frame_done !== 1'b0 || o_wr_en !== 1'b0) begin
            errors++; $display("FAIL %s_done_pulse got done=%b en=%b exp 0/0", name, o_frame_done, o_wr_en);
        end
    endtask

    task automatic test_backpressure();
        int hs0;
        int sum0;
        apply_reset();
        hs0 = hs_count; sum0 = hs_addr_sum;
        @(negedge clk100);
        i_start = 1'b1; i_wr_ready = 1'b1;
        @(negedge clk100);
        i_start = 1'b0; i_valid = 1'b1; i_pixel = 19'(1280);
        @(negedge clk100);
        checks++;
        if (o_wr_en !== 1'b1 || o_wr_addr !== 19'd0 || o_wr_data !== 7'd5) begin
            errors++; $display("FAIL bp_w0 got en=%b addr=%0d data=%0d exp 1/0/5", o_wr_en, o_wr_addr, o_wr_data);
        end
        i_pixel = 19'(1536);
        @(negedge clk100);
        i_pixel = 19'(1792); i_wr_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (o_wr_en !== 1'b1 || o_wr_addr !== 19'd1 || o_wr_data !== 7'd6) begin
                errors++; $display("FAIL bp_hold[%0d] got en=%b addr=%0d data=%0d exp 1/1/6",
                                   c, o_wr_en, o_wr_addr, o_wr_data);
            end
            #1;
            checks++;
            if (o_ready !== 1'b0) begin
                errors++; $display("FAIL bp_ready_low[%0d] got=%b exp=0", c, o_ready);
            end
            @(negedge clk100);
        end
        checks++;
        if (o_wr_en !== 1'b1 || o_wr_addr !== 19'd1 || o_wr_data !== 7'd6) begin
            errors++; $display("FAIL bp_release got en=%b addr=%0d data=%0d exp 1/1/6", o_wr_en, o_wr_addr, o_wr_data);
        end
        i_wr_ready = 1'b1;
        #1;
        checks++;
        if (o_ready !== 1'b1) begin
            errors++; $display("FAIL bp_ready_back got=%b exp=1", o_ready);
        end
        @(negedge clk100);
        checks++;
        if (o_wr_addr !== 19'd2 || o_wr_data !== 7'd7) begin
            errors++; $display("FAIL bp_w2 got addr=%0d data=%0d exp 2/7", o_wr_addr, o_wr_data);
        end
        i_pixel = 19'(2048);
        @(negedge clk100);
        checks++;
        if (o_wr_addr !== 19'd3 || o_wr_data !== 7'd8) begin
            errors++; $display("FAIL bp_w3 got addr=%0d data=%0d exp 3/8", o_wr_addr, o_wr_data);
        end
        i_valid = 1'b0;
        @(negedge clk100);
        checks++;
        if (o_frame_done !== 1'b1) begin
            errors++; $display("FAIL bp_done got=%b exp=1", o_frame_done);
        end
        checks++;
        if (hs_count - hs0 !== 4 || hs_addr_sum - sum0 !== 6) begin
            errors++; $display("FAIL bp_writes got count=%0d addrsum=%0d exp 4/6", hs_count - hs0, hs_addr_sum - sum0);
        end
    endtask

    task automatic test_start_rules();
        apply_reset();
        i_valid = 1'b1; i_pixel = 19'(1280); i_wr_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk100);
            checks++;
            if (o_wr_en !== 1'b0 || o_ready !== 1'b0) begin
                errors++; $display("FAIL nostart[%0d] got en=%b ready=%b exp 0/0", c, o_wr_en, o_ready);
            end
        end
        i_valid = 1'b0; i_start = 1'b1;
        @(negedge clk100);
        i_start = 1'b0; i_valid = 1'b1; i_pixel = 19'(1280);
        @(negedge clk100);
        checks++;
        if (o_wr_addr !== 19'd0 || o_wr_en !== 1'b1) begin
            errors++; $display("FAIL restart_w0 got addr=%0d en=%b exp 0/1", o_wr_addr, o_wr_en);
        end
        i_start = 1'b1; i_pixel = 19'(1536);
        @(negedge clk100);
        i_start = 1'b0; i_pixel = 19'(1792);
        checks++;
        if (o_wr_addr !== 19'd1 || o_wr_data !== 7'd6 || o_busy !== 1'b1) begin
            errors++; $display("FAIL restart_w1 got addr=%0d data=%0d busy=%b exp 1/6/1", o_wr_addr, o_wr_data, o_busy);
        end
        @(negedge clk100);
        i_pixel = 19'(2048);
        checks++;
        if (o_wr_addr !== 19'd2 || o_wr_data !== 7'd7) begin
            errors++; $display("FAIL restart_w2 got addr=%0d data=%0d exp 2/7", o_wr_addr, o_wr_data);
        end
        @(negedge clk100);
        i_valid = 1'b0;
        checks++;
        if (o_wr_addr !== 19'd3 || o_wr_data !== 7'd8) begin
            errors++; $display("FAIL restart_w3 got addr=%0d data=%0d exp 3/8", o_wr_addr, o_wr_data);
        end
        @(negedge clk100);
        checks++;
        if (o_frame_done !== 1'b1) begin
            errors++; $display("FAIL restart_done got=%b exp=1", o_frame_done);
        end
    endtask

    initial begin
        test_reset();
        test_frame("b2b", px_b2b, ex_b2b);
        test_frame("clamp", px_clp, ex_clp);
        test_backpressure();
        test_frame("round", px_rnd, ex_rnd);
        test_start_rules();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
